i2c_target_responder: RTL and testbench

I2C_TARGET_RESPONDER -- requirements
Module: i2c_target_responder

---
 rtl/i2c_target_responder.sv | 144 ++++++++++++++
 tb/tb_i2c_target_responder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_responder.sv
// i2c_target_responder: I2C target at DEV_ADDR with a 16-bit write capture and a 16-bit read source.
// Define I2C_TARGET_GLITCH_FILTER_EN to add a 3-sample majority filter on SCL/SDA ahead of edge detection.
module i2c_target_responder #(
  parameter logic [6:0] DEV_ADDR = 7'h60
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  output logic [15:0] wr_data,
  output logic        wr_bytes,
  output logic        wr_valid,
  input  logic [15:0] rd_data,
  output logic        rd_strobe,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE} state_t;
  state_t state, state_n;
  logic scl_s1, scl_s2, sda_s1, sda_s2, scl_f, sda_f, scl_d, sda_d;
  logic rise, fall, start, stop, match, ack, oe_n, rw, rd_lo, flush;
  logic [3:0] bitcnt;
  logic [7:0] sh, tx, nb;
  logic [15:0] rd_buf, wr_buf;
  logic [1:0] wr_cnt;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {scl_s1, scl_s2, sda_s1, sda_s2, scl_d, sda_d} <= '1;
    else begin
      {scl_s1, scl_s2, sda_s1, sda_s2} <= {scl_in, scl_s1, sda_in, sda_s1};
      {scl_d, sda_d} <= {scl_f, sda_f};
    end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [1:0] scl_h, sda_h;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {scl_h, sda_h} <= '1;
    else begin
      scl_h <= {scl_h[0], scl_s2};
      sda_h <= {sda_h[0], sda_s2};
    end
  assign scl_f = (scl_s2 & scl_h[0]) | (scl_s2 & scl_h[1]) | (scl_h[0] & scl_h[1]);
  assign sda_f = (sda_s2 & sda_h[0]) | (sda_s2 & sda_h[1]) | (sda_h[0] & sda_h[1]);
`else
  assign scl_f = scl_s2;
  assign sda_f = sda_s2;
`endif

  assign rise  = scl_f & ~scl_d;
  assign fall  = ~scl_f & scl_d;
  assign start = scl_f & scl_d & sda_d & ~sda_f;
  assign stop  = scl_f & scl_d & ~sda_d & sda_f;
  assign match = sh[7:1] == DEV_ADDR;
  assign ack   = ~sh[0];
  assign nb    = (state == ADDR_ACK || rd_lo) ? rd_buf[15:8] : rd_buf[7:0];
  assign busy  = state != IDLE;

  always_comb begin
    state_n = state;
    oe_n = sda_oe;
    if (stop) begin
      state_n = IDLE;
      oe_n = 1'b0;
    end else if (start) begin
      state_n = ADDR;
      oe_n = 1'b0;
    end else if (fall)
      case (state)
        ADDR: if (bitcnt == 4'd8) begin
          state_n = match ? ADDR_ACK : IGNORE;
          oe_n = match;
        end
        ADDR_ACK: begin
          state_n = rw ? RD_BYTE : WR_BYTE;
          oe_n = rw & ~nb[7];
        end
        WR_BYTE: if (bitcnt == 4'd8) begin
          state_n = wr_cnt == 2'd2 ? IGNORE : WR_ACK;
          oe_n = wr_cnt != 2'd2;
        end
        WR_ACK: begin
          state_n = WR_BYTE;
          oe_n = 1'b0;
        end
        RD_BYTE: begin
          state_n = bitcnt == 4'd8 ? RD_ACK : RD_BYTE;
          oe_n = (bitcnt != 4'd8) & ~tx[7];
        end
        RD_ACK: begin
          state_n = ack ? RD_BYTE : IGNORE;
          oe_n = ack & ~nb[7];
        end
        default: ;
      endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      sda_oe <= 1'b0;
    end else begin
      state <= state_n;
      sda_oe <= oe_n;
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {rd_strobe, flush, wr_valid, wr_bytes, rw, rd_lo} <= '0;
      {sh, tx, bitcnt, wr_cnt} <= '0;
      {wr_data, wr_buf, rd_buf} <= '0;
    end else begin
      rd_strobe <= fall && state == ADDR && bitcnt == 4'd8 && match && sh[0];
      flush <= (start | stop) && wr_cnt != 2'd0;
      wr_valid <= flush;
      if (rise) begin
        sh <= {sh[6:0], sda_f};
        bitcnt <= bitcnt + 4'd1;
      end
      if (start | stop) begin
        bitcnt <= 4'd0;
        wr_cnt <= 2'd0;
        if (wr_cnt != 2'd0) begin
          wr_data <= wr_cnt == 2'd1 ? {wr_buf[15:8], 8'h00} : wr_buf;
          wr_bytes <= wr_cnt[1];
        end
      end else if (fall) begin
        if (state inside {ADDR_ACK, WR_ACK, RD_ACK}) bitcnt <= 4'd0;
        if (state == ADDR && bitcnt == 4'd8) begin
          rw <= sh[0];
          if (match && sh[0]) rd_buf <= rd_data;
        end
        if (state == WR_BYTE && bitcnt == 4'd8 && wr_cnt != 2'd2) begin
          wr_cnt <= wr_cnt + 2'd1;
          if (wr_cnt == 2'd0) wr_buf[15:8] <= sh;
          else wr_buf[7:0] <= sh;
        end
        if (state == ADDR_ACK || (state == RD_ACK && ack)) begin
          tx <= {nb[6:0], 1'b0};
          rd_lo <= state == RD_ACK && !rd_lo;
        end
        if (state == RD_BYTE && bitcnt != 4'd8) tx <= {tx[6:0], 1'b0};
      end
    end
endmodule

// File: tb/tb_i2c_target_responder.sv
// tb_i2c_target_responder: directed I2C controller transactions against i2c_target_responder.
module tb_i2c_target_responder;
  logic clk = 1'b0, rst_n = 1'b0, scl_in = 1'b1, sda_m = 1'b1;
  logic sda_in, sda_oe, wr_bytes, wr_valid, rd_strobe, busy;
  logic [15:0] wr_data, rd_data = 16'h0000;
  int checks = 0, errors = 0, wv_cnt = 0, rs_cnt = 0, oe_cnt = 0, lat = 0;
  logic [15:0] wv_data = 16'h0;
  logic wv_bytes = 1'b0, rs_oe = 1'b0;
`ifdef I2C_TARGET_GLITCH_FILTER_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 4;
`endif

  assign sda_in = sda_m & ~sda_oe;
  always #5 clk = ~clk;

  i2c_target_responder #(.DEV_ADDR(7'h60)) dut (
    .clk(clk), .rst_n(rst_n), .scl_in(scl_in), .sda_in(sda_in), .sda_oe(sda_oe),
    .wr_data(wr_data), .wr_bytes(wr_bytes), .wr_valid(wr_valid),
    .rd_data(rd_data), .rd_strobe(rd_strobe), .busy(busy)
  );

  always @(negedge clk) begin
    if (wr_valid) begin
      wv_cnt++;
      wv_data = wr_data;
      wv_bytes = wr_bytes;
    end
    if (rd_strobe) begin
      rs_cnt++;
      rs_oe = sda_oe;
    end
    if (sda_oe) oe_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; #100;
    scl_in = 1'b1; #100;
    sda_m = 1'b0; #200;
    scl_in = 1'b0; #100;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; #100;
    scl_in = 1'b1; #200;
    sda_m = 1'b1;
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      #10;
      if (wr_valid && lat == 0) lat = i;
    end
    #120;
  endtask

  task automatic write_bit(input logic b, input logic g);
    sda_m = b; #100;
    scl_in = 1'b1;
    if (g) begin
      #100; scl_in = 1'b0; #10; scl_in = 1'b1; #90;
    end else #200;
    scl_in = 1'b0; #100;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gbit, output logic a);
    for (int i = 7; i >= 0; i--) write_bit(b[i], i == gbit);
    sda_m = 1'b1; #100;
    scl_in = 1'b1; #100;
    a = ~sda_in; #100;
    scl_in = 1'b0; #100;
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] b);
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      sda_m = 1'b1; #100;
      scl_in = 1'b1; #100;
      b = {b[6:0], sda_in}; #100;
      scl_in = 1'b0; #100;
    end
    sda_m = ~mack; #100;
    scl_in = 1'b1; #200;
    scl_in = 1'b0; #100;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic a;
    logic [7:0] b;
    int w0, r0, o0;
    #20;
    check("rst_oe", sda_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_wv", wr_valid, 0);
    check("rst_rs", rd_strobe, 0);
    check("rst_wdata", wr_data, 16'h0000);
    check("rst_wbytes", wr_bytes, 0);
    #80 rst_n = 1'b1;
    #100;
    // two-byte write
    w0 = wv_cnt;
    i2c_start();
    send_byte(8'hC0, -1, a); check("w_addr_ack", a, 1);
    send_byte(8'h12, -1, a); check("w_b1_ack", a, 1);
    send_byte(8'h34, -1, a); check("w_b2_ack", a, 1);
    check("w_busy", busy, 1);
    i2c_stop();
    check("w_latency", lat, LAT);
    check("w_cnt", wv_cnt - w0, 1);
    check("w_data", wv_data, 16'h1234);
    check("w_bytes", wv_bytes, 1);
    check("w_idle", busy, 0);
    // wrong address
    w0 = wv_cnt; o0 = oe_cnt;
    i2c_start();
    send_byte(8'hC2, -1, a); check("na_addr_ack", a, 0);
    send_byte(8'h55, -1, a); check("na_b1_ack", a, 0);
    check("na_busy", busy, 1);
    i2c_stop();
    check("na_oe", oe_cnt - o0, 0);
    check("na_wv", wv_cnt - w0, 0);
    check("na_idle", busy, 0);
    // read A55A, ACK then NACK; rd_data changes after latch
    rd_data = 16'hA55A; r0 = rs_cnt;
    i2c_start();
    send_byte(8'hC1, -1, a); check("r_addr_ack", a, 1);
    rd_data = 16'h0000;
    read_byte(1'b1, b); check("r_b1", b, 8'hA5);
    read_byte(1'b0, b); check("r_b2", b, 8'h5A);
    check("r_oe_nack", sda_oe, 0);
    check("r_strobe_cnt", rs_cnt - r0, 1);
    check("r_strobe_oe", rs_oe, 1);
    i2c_stop();
    // third write byte NACKed
    w0 = wv_cnt;
    i2c_start();
    send_byte(8'hC0, -1, a); check("w3_addr_ack", a, 1);
    send_byte(8'hDE, -1, a); check("w3_b1_ack", a, 1);
    send_byte(8'hAD, -1, a); check("w3_b2_ack", a, 1);
    send_byte(8'hBE, -1, a); check("w3_b3_nack", a, 0);
    i2c_stop();
    check("w3_cnt", wv_cnt - w0, 1);
    check("w3_data", wv_data, 16'hDEAD);
    check("w3_bytes", wv_bytes, 1);
    // one-byte write then repeated start into read
    w0 = wv_cnt; r0 = rs_cnt; rd_data = 16'hC33C;
    i2c_start();
    send_byte(8'hC0, -1, a); check("rs_addr_ack", a, 1);
    send_byte(8'h7F, -1, a); check("rs_b1_ack", a, 1);
    i2c_start();
    check("rs_wv_cnt", wv_cnt - w0, 1);
    check("rs_data", wv_data, 16'h7F00);
    check("rs_bytes", wv_bytes, 0);
    send_byte(8'hC1, -1, a); check("rs_rd_ack", a, 1);
    check("rs_strobe", rs_cnt - r0, 1);
    read_byte(1'b0, b); check("rs_rd_b1", b, 8'hC3);
    i2c_stop();
    check("rs_wv_final", wv_cnt - w0, 1);
    // read wraps back to the high byte
    rd_data = 16'h1234;
    i2c_start();
    send_byte(8'hC1, -1, a); check("wrap_ack", a, 1);
    read_byte(1'b1, b); check("wrap_b1", b, 8'h12);
    read_byte(1'b1, b); check("wrap_b2", b, 8'h34);
    read_byte(1'b0, b); check("wrap_b3", b, 8'h12);
    i2c_stop();
    // reset while driving SDA low in a read
    rd_data = 16'h0000;
    i2c_start();
    send_byte(8'hC1, -1, a); check("mr_ack", a, 1);
    check("mr_oe_before", sda_oe, 1);
    #3 rst_n = 1'b0;
    #1;
    check("mr_oe_after", sda_oe, 0);
    check("mr_busy", busy, 0);
    #106 rst_n = 1'b1;
    #100;
    write_bit(1'b0, 1'b0);
    write_bit(1'b1, 1'b0);
    check("mr_no_start", busy, 0);
    i2c_stop();
    w0 = wv_cnt;
    i2c_start();
    send_byte(8'hC0, -1, a); check("mr_new_ack", a, 1);
    send_byte(8'hAB, -1, a);
    i2c_stop();
    check("mr_new_cnt", wv_cnt - w0, 1);
    check("mr_new_data", wv_data, 16'hAB00);
    check("mr_new_bytes", wv_bytes, 0);
`ifdef I2C_TARGET_GLITCH_FILTER_EN
    i2c_start();
    send_byte(8'hC0, -1, a);
    send_byte(8'h96, 3, a); check("gl_b1_ack", a, 1);
    send_byte(8'h3C, 5, a); check("gl_b2_ack", a, 1);
    i2c_stop();
    check("gl_data", wv_data, 16'h963C);
    check("gl_bytes", wv_bytes, 1);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
